mem_stream_bridge: RTL and testbench



---
 rtl/mem_stream_bridge.sv | 185 ++++++++++++++++++
 tb/tb_mem_stream_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_bridge.sv
// Byte-stream bridge between a UART-style RX/TX byte stream and an 8-bit single-port synchronous memory.
// Optional running checksum enabled by defining BRIDGE_CHECKSUM_EN; otherwise checksum reads 8'h00.
module mem_stream_bridge #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_en,
    output logic              mem_wea,
    output logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_TX_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   lenq_q, lenq_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ADDR_W:0]   len_clamped_s;

    // Any length with the top bit set is at least the memory depth.
    assign len_clamped_s = len[ADDR_W] ? DEPTH_LEN : len;

    // Next-state and memory/stream handshake decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        lenq_d    = lenq_q;
        tx_data_d = tx_data_q;
        mem_en    = 1'b0;
        mem_wea   = 1'b0;
        mem_din   = 8'h00;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start || dump_start) begin
                    ptr_d  = base_addr;
                    cnt_d  = '0;
                    lenq_d = len_clamped_s;
                    if (len_clamped_s == '0) begin
                        state_d = S_DONE;
                    end else if (load_start) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Reset in flight must not let the memory see one more write.
                rx_ready = ~Rst;
                if (rx_valid) begin
                    mem_en  = ~Rst;
                    mem_wea = ~Rst;
                    mem_din = rx_data;
                    ptr_d   = ptr_q + PTR_ONE;
                    cnt_d   = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == lenq_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RD_ISSUE: begin
                mem_en  = ~Rst;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_data_d = mem_dout;
                state_d   = S_TX_HOLD;
            end
            S_TX_HOLD: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    ptr_d = ptr_q + PTR_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == lenq_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end else begin
                    state_d = S_TX_HOLD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output-data registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            lenq_q    <= '0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            lenq_q    <= lenq_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef BRIDGE_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    // Checksum follows the byte counter: clear on start, add each transferred byte.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && (load_start || dump_start)) begin
            checksum_d = 8'h00;
        end else if (state_q == S_LOAD && rx_valid) begin
            checksum_d = checksum_q + rx_data;
        end else if (state_q == S_TX_HOLD && tx_ready) begin
            checksum_d = checksum_q + tx_data_q;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign mem_addr = ptr_q;
    assign tx_data  = tx_data_q;
    assign count    = cnt_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_stream_bridge.sv
// Self-checking bench for mem_stream_bridge: behavioural memory, reference image and
// directed plus randomized LOAD/DUMP sequences.
module tb_mem_stream_bridge;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
`ifdef BRIDGE_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          Rst = 1'b1;
    logic          load_start = 1'b0;
    logic          dump_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          mem_en;
    logic          mem_wea;
    logic [7:0]    mem_din;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout = 8'h00;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [7:0]    checksum;

    int compared = 0;
    int mismatched = 0;
    int wr_count = 0;
    int done_count = 0;

    logic [7:0] mem     [0:DEPTH-1] = '{default: 8'h00};
    logic [7:0] ref_mem [0:DEPTH-1] = '{default: 8'h00};
    logic [7:0] load_data [0:DEPTH-1];

    mem_stream_bridge #(.ADDR_W(AW)) dut (
        .clk(clk), .Rst(Rst), .load_start(load_start), .dump_start(dump_start),
        .base_addr(base_addr), .len(len), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_din(mem_din), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .busy(busy), .done(done), .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory with registered read data, plus event counters.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wea) begin
                mem[mem_addr] <= mem_din;
                wr_count      <= wr_count + 1;
            end
            mem_dout <= mem[mem_addr];
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_wea"}, mem_wea, 0);
        check({tag, "_mem_din"}, mem_din, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    task automatic check_image(input string tag);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) bad++;
        check(tag, bad, 0);
    endtask

    // Post-operation checks shared by load and dump: DONE cycle then IDLE.
    task automatic finish_op(input string tag, input int lq, input logic [7:0] sum,
                             input int wr0, input int exp_writes, input int dn0);
        #1;
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_done_busy"}, busy, 1);
        check({tag, "_done_mem_en"}, mem_en, 0);
        check({tag, "_count"}, count, lq);
        check({tag, "_checksum"}, checksum, CSUM_ON ? sum : 8'h00);
        @(negedge clk);
        load_start = 1'b0;
        dump_start = 1'b0;
        #1;
        check({tag, "_idle_done"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_count_hold"}, count, lq);
        check({tag, "_writes"}, wr_count - wr0, exp_writes);
        check({tag, "_done_cnt"}, done_count - dn0, 1);
    endtask

    task automatic run_load(input string tag, input int base, input int ln,
                            input bit both, input int gap_pct);
        int lq = (ln > DEPTH) ? DEPTH : ln;
        int idx = 0;
        int cyc = 0;
        int wr0 = wr_count;
        int dn0 = done_count;
        logic [7:0] sum = 8'h00;
        @(negedge clk);
        base_addr  = base[AW-1:0];
        len        = ln[AW:0];
        load_start = 1'b1;
        dump_start = both;
        @(negedge clk);
        load_start = 1'b0;
        dump_start = 1'b0;
        while (idx < lq && cyc < lq * 4 + 20) begin
            rx_valid   = ($urandom_range(99) >= gap_pct);
            rx_data    = rx_valid ? load_data[idx] : 8'($urandom);
            dump_start = 1'($urandom_range(1));
            #1;
            check({tag, "_rx_ready"}, rx_ready, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_mem_en"}, mem_en, rx_valid);
            check({tag, "_mem_addr"}, mem_addr, (base + idx) % DEPTH);
            check({tag, "_no_early_done"}, done, 0);
            if (rx_valid) begin
                ref_mem[(base + idx) % DEPTH] = load_data[idx];
                sum = sum + load_data[idx];
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        rx_valid   = 1'b0;
        dump_start = 1'b0;
        if (idx < lq) check({tag, "_timeout"}, idx, lq);
        finish_op(tag, lq, sum, wr0, lq, dn0);
        check_image({tag, "_image"});
    endtask

    task automatic run_dump(input string tag, input int base, input int ln, input bit toggle);
        int lq = (ln > DEPTH) ? DEPTH : ln;
        int idx = 0;
        int cyc = 0;
        int prev_hs = -1;
        bit await_valid = 1'b1;
        int wr0 = wr_count;
        int dn0 = done_count;
        logic [7:0] sum = 8'h00;
        @(negedge clk);
        base_addr  = base[AW-1:0];
        len        = ln[AW:0];
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        while (idx < lq && cyc < lq * 8 + 20) begin
            tx_ready   = toggle ? (cyc % 2 == 0) : 1'($urandom_range(1));
            load_start = 1'($urandom_range(1));
            #1;
            check({tag, "_no_write"}, mem_wea, 0);
            check({tag, "_busy"}, busy, 1);
            if (tx_valid) begin
                if (await_valid) begin
                    check({tag, "_latency"}, cyc - prev_hs, 3);
                    await_valid = 1'b0;
                end
                check({tag, "_data"}, tx_data, ref_mem[(base + idx) % DEPTH]);
                if (tx_ready) begin
                    sum = sum + ref_mem[(base + idx) % DEPTH];
                    idx++;
                    prev_hs = cyc;
                    await_valid = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready   = 1'b0;
        load_start = 1'b0;
        if (idx < lq) check({tag, "_timeout"}, idx, lq);
        finish_op(tag, lq, sum, wr0, 0, dn0);
    endtask

    initial begin
        int wr0;
        int dn0;
        int b;
        int n;

        // Reset state after one edge
        @(negedge clk);
        check_all_zero("reset");
        Rst = 1'b0;

        // Directed load and toggled-ready dump
        load_data[0] = 8'hA5; load_data[1] = 8'h3C; load_data[2] = 8'hFF; load_data[3] = 8'h00;
        run_load("load4", 0, 4, 1'b0, 0);
        run_dump("dump4", 0, 4, 1'b1);

        // Wrap-around at the top of memory
        load_data[0] = 8'h11; load_data[1] = 8'h22; load_data[2] = 8'h33;
        run_load("wrap", 1022, 3, 1'b0, 0);
        check("wrap_1022", mem[1022], 8'h11);
        check("wrap_1023", mem[1023], 8'h22);
        check("wrap_0", mem[0], 8'h33);
        run_dump("wrap_dump", 1022, 3, 1'b0);

        // Zero length and clamped length
        run_load("len0", 5, 0, 1'b0, 0);
        run_dump("dlen0", 5, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) load_data[i] = 8'($urandom);
        run_load("clamp", 17, 2000, 1'b0, 0);

        // Simultaneous starts: load wins, dump pokes while busy ignored
        for (int i = 0; i < 4; i++) load_data[i] = 8'($urandom);
        run_load("both", 100, 4, 1'b1, 20);

        // Reset after 2 of 5 load bytes
        for (int i = 0; i < 5; i++) load_data[i] = 8'h40 + 8'(i);
        wr0 = wr_count;
        dn0 = done_count;
        @(negedge clk);
        base_addr = 10'd200;
        len = 11'd5;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'b1;
            rx_data = load_data[i];
            ref_mem[200 + i] = load_data[i];
            @(negedge clk);
        end
        Rst = 1'b1;
        rx_data = load_data[2];
        #1;
        check("rst_gate_mem_en", mem_en, 0);
        @(negedge clk);
        #1;
        check_all_zero("abort");
        Rst = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("abort_writes", wr_count - wr0, 2);
        check("abort_no_done", done_count - dn0, 0);
        check_image("abort_image");

        // Randomized load/dump pairs
        for (int t = 0; t < 8; t++) begin
            b = (t % 3 == 0) ? 1000 + $urandom_range(23) : $urandom_range(DEPTH - 1);
            n = $urandom_range(40);
            for (int i = 0; i < n; i++) load_data[i] = 8'($urandom);
            run_load("rnd_load", b, n, 1'($urandom_range(1)), 30);
            run_dump("rnd_dump", b, n, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
